reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file; successor to the single-port RV32I register file.
- Adds configurable width, depth and read-port count, same-cycle write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard.
- Sits between decode/issue (read, allocate) and writeback (write) in the Ripple-32 core.

Parameters:
- XLEN, 32, data width of each register in bits.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), register address width.
- NUM_RD, 2, number of independent read ports, 1..4.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  output  NUM_RD  1 = register read on port i has an outstanding producer.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  XLEN  write data.
- alloc_en  input  1  mark alloc_addr busy (new producer issued).
- alloc_addr  input  ADDR_W  register being allocated.
- flush  input  1  clear all busy bits.

Behaviour:
- Reset (async, rst=1):
  - All registers := 0; all busy bits := 0.
  - rd_data and rd_busy are combinational, so they read 0 for every address while rst is held.
  - Reset asserted mid-operation discards any in-flight write or alloc; no edge commits while rst=1.
- Writes:
  - On a rising edge with we=1, reg[waddr] := wdata.
  - When ZERO_REG=1 and waddr=0, the write is dropped.
- Reads:
  - Combinational, zero latency: rd_data[i] = reg[rd_addr[i]].
  - Bypass: when BYPASS=1, we=1 and waddr=rd_addr[i] (and not the dropped register-0 case), rd_data[i] = wdata in the same cycle.
  - When BYPASS=0, the written value is visible from the cycle after the edge.
  - Ports are fully independent; any number of ports may read the same address.
  - ZERO_REG=1 with rd_addr[i]=0: rd_data[i]=0 and rd_busy[i]=0 always.
- Busy scoreboard, next-state priority per register r, highest first:
  1. flush=1: busy[r] := 0 for all r.
  2. alloc_en=1 and alloc_addr=r: busy[r] := 1. Alloc beats a same-cycle write to the same address, because the new producer is younger.
  3. we=1 and waddr=r: busy[r] := 0.
  4. Otherwise busy[r] holds.
  - alloc_addr=0 is ignored when ZERO_REG=1.
  - A write to a non-busy register is legal; busy stays 0.
  - A second alloc of an already-busy register is legal; busy stays 1.
- rd_busy[i] combinational:
  - Equals busy[rd_addr[i]].
  - When BYPASS=1 and a same-cycle write to rd_addr[i] is occurring, rd_busy[i]=0, because the data is being forwarded.
  - A same-cycle alloc or flush does not affect the current-cycle rd_busy; it takes effect after the edge.
- Write and flush together: the data write still commits; only busy bits are cleared.
- Address range: no out-of-range addresses exist, since DEPTH = 2^ADDR_W.

Test Plan:
- Reset: hold rst=1, read all 32 addresses on both ports -> every rd_data=0 and rd_busy=0. Release rst, write x5=0xDEADBEEF, read x5 next cycle -> 0xDEADBEEF.
- Zero register: write x0=0xFFFFFFFF and alloc x0 -> rd_data=0 and rd_busy=0 on x0 in every following cycle.
- Bypass: BYPASS=1, we=1, waddr=7, wdata=0x12345678, rd_addr[0]=7 in the same cycle -> rd_data[0]=0x12345678, rd_busy[0]=0. Repeat with BYPASS=0 -> old value, then new value the next cycle.
- Scoreboard life cycle: alloc x10 -> rd_busy on x10 = 1 from the next cycle. Write x10=0x55 three cycles later -> rd_busy=0 in the write cycle (bypass) and busy cleared after the edge.
- Simultaneous events:
  - Alloc x3 and write x3=0xA in the same cycle -> x3 reads 0xA and busy=1 next cycle.
  - Flush with alloc x4 in the same cycle -> x4 busy=0.
- Async reset mid-stream: busy x1, x2, then assert rst between edges -> outputs 0 immediately, no pending state survives release. Also run with NUM_RD=4, XLEN=64, DEPTH=16 -> all four ports read distinct registers correctly.

Source files
------------

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
//
// Parametrised multi-read-port register file for the Ripple-32 core. It sits
// between decode/issue (reads, producer allocation) and writeback (writes).
//
// Features:
//   - XLEN-bit wide, DEPTH-entry register array, NUM_RD independent
//     combinational read ports.
//   - Optional same-cycle write-to-read bypass (BYPASS).
//   - Optional hardwired zero register at address 0 (ZERO_REG).
//   - Per-register busy scoreboard: alloc marks a register as having an
//     outstanding producer, a write retires it, flush clears everything.
//
// Ports:
//   clk         core clock, all state changes on the rising edge
//   rst         asynchronous active-high reset (clears data and busy bits)
//   rd_addr     NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data     NUM_RD packed read data, port i at [i*XLEN +: XLEN]
//   rd_busy     per-port busy flag of the register being read
//   we          write enable
//   waddr       write address
//   wdata       write data
//   alloc_en    mark alloc_addr busy (new producer issued)
//   alloc_addr  register being allocated
//   flush       clear every busy bit
// -----------------------------------------------------------------------------
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic                     flush
);

    localparam bit HAS_ZERO   = (ZERO_REG != 0);
    localparam bit HAS_BYPASS = (BYPASS != 0);

    // Register storage and scoreboard. Reads are asynchronous and the array
    // is cleared by reset, so this maps to distributed logic, not block RAM.
    logic [XLEN-1:0]  regs_q [DEPTH];
    logic [XLEN-1:0]  regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // One-hot decodes of the write and alloc addresses.
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] alloc_hit;

    // A write or alloc aimed at the hardwired zero register is dropped here,
    // so neither the data array nor the scoreboard ever sees it.
    logic wr_valid;
    logic alloc_valid;

    always_comb begin
        wr_valid    = we       && !(HAS_ZERO && (waddr == '0));
        alloc_valid = alloc_en && !(HAS_ZERO && (alloc_addr == '0));
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign wr_hit[gi]    = wr_valid    && (waddr == ADDR_W'(gi));
            assign alloc_hit[gi] = alloc_valid && (alloc_addr == ADDR_W'(gi));
        end
    endgenerate

    // Next-state per register. Busy priority: flush, then alloc, then write.
    // Alloc wins over a same-cycle write because the allocating producer is
    // younger than the one that is retiring.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = wr_hit[r] ? wdata : regs_q[r];
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (alloc_hit[r]) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
    end

    // Data writes commit even under flush; flush only touches busy bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    // Read ports: fully independent, combinational.
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              is_zero;
            logic              fwd;
            logic [XLEN-1:0]   data;
            logic              busy;

            always_comb begin
                addr    = rd_addr[gi*ADDR_W +: ADDR_W];
                is_zero = HAS_ZERO && (addr == '0);
                // wr_valid already excludes the dropped register-0 write.
                fwd     = HAS_BYPASS && wr_valid && (waddr == addr);
                data    = regs_q[addr];
                busy    = busy_q[addr];
                // A forwarded value is the producer's result, so the
                // consumer no longer has to wait for it.
                if (fwd) begin
                    data = wdata;
                    busy = 1'b0;
                end
                // While reset is held the bypass path must not leak wdata.
                if (is_zero || rst) begin
                    data = '0;
                    busy = 1'b0;
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = data;
            assign rd_busy[gi]              = busy;
        end
    endgenerate

endmodule
